// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer commit controller: default sizing,
// the per-entry lifecycle state and the entry record stored in the buffer.
package rob_pkg;

  localparam int ROB_DEPTH  = 8;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
  localparam int ROB_ADDR_W = 5;
  localparam int ROB_DATA_W = 32;

  typedef enum logic [1:0] {
    ENT_FREE  = 2'd0,
    ENT_ALLOC = 2'd1,
    ENT_DONE  = 2'd2
  } entry_state_e;

  // Field widths come from the package defaults; the controller casts its
  // ADDR_W/DATA_W ports onto these fields.
  typedef struct packed {
    entry_state_e            state;
    logic [ROB_ADDR_W-1:0]   addr;
    logic [ROB_DATA_W-1:0]   data;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctr.sv
// Circular-buffer pointer with an extra wrap bit above the index bits.
// Load takes priority over increment; the index wraps naturally (power-of-two depth).
module rob_ptr_ctr #(
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [PTR_W-1:0] load_val,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rob_commit_controller.sv
// Reorder-buffer commit controller: allocates entries in order, collects
// out-of-order writebacks, squashes on mispredict and retires one entry per cycle.
module rob_commit_controller
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int DATA_W = ROB_DATA_W,
  parameter int ADDR_W = ROB_ADDR_W,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush_valid,
  input  logic [TAG_W-1:0]  flush_tag,
  output logic              commit_valid,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [DATA_W-1:0] commit_data,
  output logic              full,
  output logic              empty,
  output logic [TAG_W:0]    count
);

  logic [TAG_W:0]   head_ptr;
  logic [TAG_W:0]   tail_ptr;
  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;

  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];

  logic              commit_valid_q, commit_valid_d;
  logic [ADDR_W-1:0] commit_addr_q,  commit_addr_d;
  logic [DATA_W-1:0] commit_data_q,  commit_data_d;

  logic             alloc_fire;
  logic             commit_fire;
  logic [TAG_W-1:0] flush_off;
  logic             flush_hit;
  logic [TAG_W:0]   flush_load_val;
  logic [DEPTH-1:0] squash;

  assign head_idx = head_ptr[TAG_W-1:0];
  assign tail_idx = tail_ptr[TAG_W-1:0];

  assign count = tail_ptr - head_ptr;
  assign empty = (head_ptr == tail_ptr);
  assign full  = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);

  // A same-cycle commit never frees a slot for allocation: readiness uses current state only.
  assign alloc_ready = rst & ~full & ~flush_valid;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_tag   = tail_idx;

  assign commit_fire = (entries_q[head_idx].state == ENT_DONE);

  // Age of the flush target relative to head; it is occupied only when younger than count.
  assign flush_off      = flush_tag - head_idx;
  assign flush_hit      = flush_valid && ({1'b0, flush_off} < count);
  assign flush_load_val = head_ptr + {1'b0, flush_off} + (TAG_W + 1)'(1);

  always_comb begin
    squash = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_hit
          && ((TAG_W'(i) - head_idx) > flush_off)
          && ({1'b0, TAG_W'(i) - head_idx} < count)) begin
        squash[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    if (alloc_fire) begin
      entries_d[tail_idx].state = ENT_ALLOC;
      entries_d[tail_idx].addr  = ROB_ADDR_W'(alloc_addr);
    end
    // Writebacks to FREE/DONE entries, or to entries squashed this cycle, are dropped.
    if (wb_valid && (entries_q[wb_tag].state == ENT_ALLOC) && !squash[wb_tag]) begin
      entries_d[wb_tag].state = ENT_DONE;
      entries_d[wb_tag].data  = ROB_DATA_W'(wb_data);
    end
    if (commit_fire) begin
      entries_d[head_idx].state = ENT_FREE;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (squash[i]) begin
        entries_d[i].state = ENT_FREE;
      end
    end
  end

  always_comb begin
    commit_valid_d = commit_fire;
    commit_addr_d  = commit_addr_q;
    commit_data_d  = commit_data_q;
    if (commit_fire) begin
      commit_addr_d = ADDR_W'(entries_q[head_idx].addr);
      commit_data_d = DATA_W'(entries_q[head_idx].data);
    end
  end

  // Entry payload is not reset; only the lifecycle state needs clearing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].state <= ENT_FREE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      commit_valid_q <= 1'b0;
      commit_addr_q  <= '0;
      commit_data_q  <= '0;
    end else begin
      commit_valid_q <= commit_valid_d;
      commit_addr_q  <= commit_addr_d;
      commit_data_q  <= commit_data_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_addr  = commit_addr_q;
  assign commit_data  = commit_data_q;

  rob_ptr_ctr #(
    .PTR_W (TAG_W + 1)
  ) u_head (
    .clk      (clk),
    .rst      (rst),
    .inc      (commit_fire),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (head_ptr)
  );

  rob_ptr_ctr #(
    .PTR_W (TAG_W + 1)
  ) u_tail (
    .clk      (clk),
    .rst      (rst),
    .inc      (alloc_fire),
    .load     (flush_hit),
    .load_val (flush_load_val),
    .ptr      (tail_ptr)
  );

endmodule

// File: tb/tb_rob_commit_controller.sv
// Directed bench for rob_commit_controller: in-order commit, full buffer,
// flush squash, pointer wrap, reset during activity and ignored writebacks.
module tb_rob_commit_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [31:0] wb_data;
  logic        flush_valid;
  logic [2:0]  flush_tag;
  logic        commit_valid;
  logic [4:0]  commit_addr;
  logic [31:0] commit_data;
  logic        full;
  logic        empty;
  logic [3:0]  count;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  rob_commit_controller dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_addr   (alloc_addr),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_data      (wb_data),
    .flush_valid  (flush_valid),
    .flush_tag    (flush_tag),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .commit_data  (commit_data),
    .full         (full),
    .empty        (empty),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_alloc(input logic [4:0] addr);
    alloc_valid = 1'b1;
    alloc_addr  = addr;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [2:0] tag, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_tag   = tag;
    wb_data  = data;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic chk_commit(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_v"}, commit_valid, 1'b1);
    chk({tag, "_a"}, commit_addr, a);
    chk({tag, "_d"}, commit_data, d);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] exp_tag;
    rst = 1'b0;
    alloc_valid = 1'b0; alloc_addr = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_data = '0;
    flush_valid = 1'b0; flush_tag = '0;
    step();
    step();

    // Reset state
    chk("rst_ready", alloc_ready, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_tag", alloc_tag, 3'd0);
    chk("rst_cv", commit_valid, 1'b0);
    chk("rst_ca", commit_addr, 5'd0);
    chk("rst_cd", commit_data, 32'd0);
    rst = 1'b1;
    #1;
    chk("ready_after_rst", alloc_ready, 1'b1);

    // Out-of-order writeback, in-order commit
    for (int i = 0; i < 3; i++) begin
      chk("s1_tag", alloc_tag, 3'(i));
      do_alloc(5'(i + 1));
    end
    do_wb(3'd2, 32'hA);
    chk("s1_cv0", commit_valid, 1'b0);
    do_wb(3'd0, 32'hB);
    chk("s1_cv1", commit_valid, 1'b0);
    do_wb(3'd1, 32'hC);
    chk_commit("s1_c0", 5'd1, 32'hB);
    step();
    chk_commit("s1_c1", 5'd2, 32'hC);
    step();
    chk_commit("s1_c2", 5'd3, 32'hA);
    step();
    chk("s1_idle", commit_valid, 1'b0);
    chk("s1_hold", commit_data, 32'hA);
    chk("s1_empty", empty, 1'b1);

    // Full buffer
    reset_pulse();
    for (int i = 0; i < 8; i++) do_alloc(5'(8 + i));
    chk("s2_full", full, 1'b1);
    chk("s2_count", count, 4'd8);
    chk("s2_ready", alloc_ready, 1'b0);
    do_wb(3'd0, 32'h100);
    chk("s2_cv0", commit_valid, 1'b0);
    chk("s2_ready_still0", alloc_ready, 1'b0);
    step();
    chk_commit("s2_c", 5'd8, 32'h100);
    chk("s2_ready1", alloc_ready, 1'b1);
    chk("s2_tag", alloc_tag, 3'd0);
    chk("s2_count7", count, 4'd7);

    // Reset with 4 entries DONE behind an ALLOC head
    reset_pulse();
    for (int i = 0; i < 5; i++) do_alloc(5'(i));
    for (int i = 1; i < 5; i++) do_wb(3'(i), 32'h200 + 32'(i));
    chk("s3_cv_pre", commit_valid, 1'b0);
    chk("s3_count_pre", count, 4'd5);
    rst = 1'b0;
    wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 32'h999;
    alloc_valid = 1'b1; alloc_addr = 5'd31;
    step();
    rst = 1'b1;
    wb_valid = 1'b0;
    alloc_valid = 1'b0;
    chk("s3_cv", commit_valid, 1'b0);
    chk("s3_empty", empty, 1'b1);
    chk("s3_count", count, 4'd0);
    chk("s3_cd", commit_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s3_no_stale", commit_valid, 1'b0);
    end

    // Flush squashes younger entries and a same-cycle writeback to them
    for (int i = 0; i < 6; i++) do_alloc(5'(20 + i));
    flush_valid = 1'b1; flush_tag = 3'd2;
    wb_valid = 1'b1; wb_tag = 3'd4; wb_data = 32'h44;
    #1;
    chk("s4_ready_flush", alloc_ready, 1'b0);
    step();
    flush_valid = 1'b0;
    wb_valid = 1'b0;
    chk("s4_count", count, 4'd3);
    chk("s4_tag", alloc_tag, 3'd3);
    flush_valid = 1'b1; flush_tag = 3'd6;
    step();
    flush_valid = 1'b0;
    chk("s4_oor_count", count, 4'd3);
    chk("s4_oor_tag", alloc_tag, 3'd3);
    do_alloc(5'd30);
    do_wb(3'd0, 32'h50);
    chk("s4_cv0", commit_valid, 1'b0);
    do_wb(3'd1, 32'h51);
    chk_commit("s4_c0", 5'd20, 32'h50);
    do_wb(3'd2, 32'h52);
    chk_commit("s4_c1", 5'd21, 32'h51);
    do_wb(3'd3, 32'h53);
    chk_commit("s4_c2", 5'd22, 32'h52);
    step();
    chk_commit("s4_c3", 5'd30, 32'h53);
    step();
    chk("s4_idle", commit_valid, 1'b0);
    chk("s4_empty", empty, 1'b1);

    // Commit of the flush target itself in the flush cycle empties the buffer
    do_alloc(5'd1);
    do_alloc(5'd2);
    do_wb(3'd4, 32'h77);
    flush_valid = 1'b1; flush_tag = 3'd4;
    step();
    flush_valid = 1'b0;
    chk_commit("s4b_c", 5'd1, 32'h77);
    chk("s4b_empty", empty, 1'b1);
    chk("s4b_count", count, 4'd0);

    // Writebacks to FREE and DONE entries are ignored
    do_alloc(5'd9);
    do_alloc(5'd10);
    do_wb(3'd7, 32'hBAD);
    chk("s5_cv_free", commit_valid, 1'b0);
    chk("s5_count", count, 4'd2);
    do_wb(3'd6, 32'h66);
    do_wb(3'd6, 32'hDEAD);
    chk("s5_cv_done", commit_valid, 1'b0);
    do_wb(3'd5, 32'h55);
    step();
    chk_commit("s5_c0", 5'd9, 32'h55);
    step();
    chk_commit("s5_c1", 5'd10, 32'h66);
    step();
    chk("s5_idle", commit_valid, 1'b0);
    chk("s5_hold", commit_data, 32'h66);
    chk("s5_empty", empty, 1'b1);

    // Twenty rounds through the wrap point
    exp_tag = 3'd7;
    for (int r = 0; r < 20; r++) begin
      chk("s6_tag", alloc_tag, exp_tag);
      do_alloc(5'(r));
      do_wb(exp_tag, 32'h1000 + 32'(r));
      step();
      chk_commit("s6_c", 5'(r), 32'h1000 + 32'(r));
      exp_tag = exp_tag + 3'd1;
    end
    step();
    chk("s6_idle", commit_valid, 1'b0);
    chk("s6_empty", empty, 1'b1);
    chk("s6_count", count, 4'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
